packet_flit_splitter: RTL and testbench

- Upstream neighbour of the flit collector: accepts whole PAYLOAD-bit packets from the local core interface and serialises each into FLIT_COUNT flits for the NoC injection port.
- Assigns each packet a per-node packet_id, stamps source/destination node and flit index into every flit, and buffers up to QUEUE_DEPTH packets.
- Valid/ready handshake on both sides; flit format is the one the collector unpacks.

---
 rtl/packet_flit_splitter.sv | 144 ++++++++++++++
 tb/tb_packet_flit_splitter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_flit_splitter.sv
// Packet-to-flit serialiser for the NoC injection port: queues whole packets,
// tags each with a packet_id and emits FLIT_COUNT flits per packet, MSB slice first.
module packet_flit_splitter #(
    parameter int NODE_COUNT      = 8,
    parameter int NODE_ID         = 0,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int PAYLOAD         = 32,
    parameter int FLIT_PAYLOAD    = 8,
    parameter int QUEUE_DEPTH     = 2,
    localparam int NODE_W     = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1,
    localparam int ID_W       = PACKET_ID_WIDTH,
    localparam int FLIT_COUNT = (PAYLOAD + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD,
    localparam int IDX_W      = (FLIT_COUNT > 1) ? $clog2(FLIT_COUNT) : 1,
    localparam int FLIT_WIDTH = 1 + 2 * NODE_W + FLIT_PAYLOAD + ID_W + IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [PAYLOAD-1:0]    packet_in,
    input  logic [NODE_W-1:0]     node_dest_in,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic [ID_W-1:0]       packet_id_out,
    output logic                  busy
);

    localparam int PADW  = FLIT_COUNT * FLIT_PAYLOAD;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(QUEUE_DEPTH);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(FLIT_COUNT - 1);
    localparam logic [NODE_W-1:0] NODE_START = NODE_W'(NODE_ID);

    typedef enum logic [0:0] {
        S_IDLE,
        S_SEND
    } state_e;

    state_e              state_q, state_d;
    logic [PAYLOAD-1:0]  pkt_mem_q  [QUEUE_DEPTH];
    logic [NODE_W-1:0]   dest_mem_q [QUEUE_DEPTH];
    logic [ID_W-1:0]     id_mem_q   [QUEUE_DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ID_W-1:0]     id_cnt_q, id_cnt_d;

    logic                not_empty, full, push, xfer, last, pop;
    logic [PADW-1:0]     padded;
    logic [FLIT_PAYLOAD-1:0] slices [FLIT_COUNT];
    logic [FLIT_PAYLOAD-1:0] flit_data;

    assign not_empty  = (count_q != '0);
    assign full       = (count_q == CNT_FULL);
    assign ready_in   = ce & ~full;
    assign push       = valid_in & ready_in;
    assign flit_valid = ce & (state_q == S_SEND) & not_empty;
    assign xfer       = flit_valid & flit_ready;
    assign last       = (idx_q == IDX_LAST);
    assign pop        = xfer & last;
    assign busy       = not_empty;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        idx_d    = idx_q;
        id_cnt_d = id_cnt_q;
        state_d  = state_q;

        if (xfer) begin
            idx_d = last ? '0 : idx_q + 1'b1;
        end
        if (pop) begin
            head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
        end
        if (push) begin
            tail_d   = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
            id_cnt_d = id_cnt_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        case (state_q)
            S_IDLE:  if (push) state_d = S_SEND;
            S_SEND:  if (count_d == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            id_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            id_cnt_q <= id_cnt_d;
        end
    end

    // Entry storage needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pkt_mem_q[tail_q]  <= packet_in;
            dest_mem_q[tail_q] <= node_dest_in;
            id_mem_q[tail_q]   <= id_cnt_q;
        end
    end

    always_comb begin
        padded = '0;
        padded[PADW-1 -: PAYLOAD] = pkt_mem_q[head_q];
        for (int unsigned k = 0; k < FLIT_COUNT; k++) begin
            slices[k] = padded[PADW - 1 - k * FLIT_PAYLOAD -: FLIT_PAYLOAD];
        end
        flit_data = slices[idx_q];

        flit_out      = '0;
        packet_id_out = '0;
        if (not_empty) begin
            flit_out      = {1'b1, dest_mem_q[head_q], flit_data, id_mem_q[head_q],
                             NODE_START, idx_q};
            packet_id_out = id_mem_q[head_q];
        end
    end

endmodule

// File: tb/tb_packet_flit_splitter.sv
// Bench for packet_flit_splitter: vector table, hand-written corner sequences and
// a randomized run against a queue-based reference model.
module tb_packet_flit_splitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce, valid_in, ready_in, flit_valid, flit_ready, busy;
    logic [31:0] packet_in;
    logic [2:0]  node_dest_in;
    logic [21:0] flit_out;
    logic [4:0]  packet_id_out;

    logic        r_ce, r_valid, r_ready, r_fvalid, r_fready, r_busy;
    logic [19:0] r_packet;
    logic [2:0]  r_dest;
    logic [21:0] r_flit;
    logic [4:0]  r_pid;

    packet_flit_splitter #(.NODE_ID(5)) dut (
        .clk(clk), .rst(rst), .ce(ce), .valid_in(valid_in), .ready_in(ready_in),
        .packet_in(packet_in), .node_dest_in(node_dest_in), .flit_out(flit_out),
        .flit_valid(flit_valid), .flit_ready(flit_ready),
        .packet_id_out(packet_id_out), .busy(busy)
    );

    packet_flit_splitter #(.PAYLOAD(20), .NODE_ID(2)) dut_r (
        .clk(clk), .rst(rst), .ce(r_ce), .valid_in(r_valid), .ready_in(r_ready),
        .packet_in(r_packet), .node_dest_in(r_dest), .flit_out(r_flit),
        .flit_valid(r_fvalid), .flit_ready(r_fready),
        .packet_id_out(r_pid), .busy(r_busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ce, vin;
        logic [31:0] pkt;
        logic [2:0]  dest;
        logic        fr;
        logic        e_rdy, e_fv, e_busy;
        logic [2:0]  e_dest;
        logic [7:0]  e_data;
        logic [4:0]  e_id;
        logic [1:0]  e_idx;
    } vec_t;

    typedef struct {
        logic [31:0] pkt;
        logic [2:0]  dest;
        logic [4:0]  id;
    } ent_t;

    vec_t tbl [16];
    ent_t mq [$];

    function automatic logic [21:0] mk(input logic [2:0] node, input logic [2:0] dest,
                                       input logic [7:0] data, input logic [4:0] id,
                                       input logic [1:0] idx);
        return {1'b1, dest, data, id, node, idx};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        valid_in = 1'b0;
        r_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] pkts  [3];
        logic [2:0]  dests [3];
        logic [7:0]  b4    [4];
        logic [7:0]  rb    [3];
        logic [31:0] sh;
        int          seen, midx, mid;
        logic        e_rdy, e_fv, acc;

        tbl[0]  = '{1'b1, 1'b1, 32'hDEADBEEF, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 5'd0, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 8'hDE, 5'd0, 2'd0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 8'hAD, 5'd0, 2'd1};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 8'hBE, 5'd0, 2'd2};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 8'hEF, 5'd0, 2'd3};
        tbl[5]  = '{1'b1, 1'b1, 32'hCAFEF00D, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 5'd0, 2'd0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 8'hCA, 5'd1, 2'd0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 8'hFE, 5'd1, 2'd1};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd6, 8'hF0, 5'd1, 2'd2};
        tbl[9]  = tbl[8];
        tbl[10] = tbl[8];
        tbl[11] = tbl[8];
        tbl[11].fr = 1'b1;
        tbl[12] = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 8'h0D, 5'd1, 2'd3};
        tbl[13] = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 5'd0, 2'd0};
        tbl[14] = '{1'b0, 1'b1, 32'h12345678, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 5'd0, 2'd0};
        tbl[15] = '{1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 5'd0, 2'd0};

        pkts  = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        dests = '{3'd1, 3'd2, 3'd4};
        b4    = '{8'h11, 8'h22, 8'h33, 8'h44};
        rb    = '{8'hAB, 8'hCD, 8'hE0};

        // Reset held two cycles with a packet on offer: nothing may be accepted.
        rst = 1'b1; ce = 1'b1; valid_in = 1'b1; packet_in = 32'h55555555;
        node_dest_in = 3'd7; flit_ready = 1'b1;
        r_ce = 1'b1; r_valid = 1'b0; r_packet = '0; r_dest = '0; r_fready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; valid_in = 1'b0;
        #1;
        chk("rst_ready", 32'(ready_in), 32'd1);
        chk("rst_fvalid", 32'(flit_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pid", 32'(packet_id_out), 32'd0);
        chk("rst_flit", 32'(flit_out), 32'd0);
        chk("r_rst_ready", 32'(r_ready), 32'd1);
        @(negedge clk);
        #1 chk("rst_noaccept_busy", 32'(busy), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            ce = tbl[i].ce; valid_in = tbl[i].vin; packet_in = tbl[i].pkt;
            node_dest_in = tbl[i].dest; flit_ready = tbl[i].fr;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(ready_in), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_fvalid", i), 32'(flit_valid), 32'(tbl[i].e_fv));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            if (tbl[i].e_fv) begin
                chk($sformatf("tbl%0d_flit", i), 32'(flit_out),
                    32'(mk(3'd5, tbl[i].e_dest, tbl[i].e_data, tbl[i].e_id, tbl[i].e_idx)));
                chk($sformatf("tbl%0d_pid", i), 32'(packet_id_out), 32'(tbl[i].e_id));
            end
            @(negedge clk);
        end
        ce = 1'b1; valid_in = 1'b0;

        // Queue full, then back-to-back drain with no bubble.
        do_reset(1);
        flit_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            valid_in = 1'b1; packet_in = pkts[p]; node_dest_in = dests[p];
            #1 chk($sformatf("qf_offer%0d_ready", p), 32'(ready_in), (p < 2) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        flit_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) valid_in = 1'b0;
            #1;
            chk($sformatf("qf%0d_fvalid", i), 32'(flit_valid), 32'd1);
            chk($sformatf("qf%0d_flit", i), 32'(flit_out),
                32'(mk(3'd5, dests[i / 4], 8'(i + 1), 5'(i / 4), 2'(i % 4))));
            if (i <= 4) chk($sformatf("qf%0d_ready", i), 32'(ready_in), (i == 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        #1;
        chk("qf_end_fvalid", 32'(flit_valid), 32'd0);
        chk("qf_end_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // ID counter wraps modulo 32.
        do_reset(1);
        valid_in = 1'b1; flit_ready = 1'b1; seen = 0;
        for (int c = 0; c < 400 && seen < 33; c++) begin
            packet_in = $urandom;
            #1;
            if (flit_valid && flit_out[1:0] == 2'd0) begin
                chk($sformatf("idwrap%0d_pid", seen), 32'(packet_id_out), 32'(seen % 32));
                chk($sformatf("idwrap%0d_field", seen), 32'(flit_out[9:5]), 32'(seen % 32));
                seen++;
            end
            @(negedge clk);
        end
        chk("idwrap_count", 32'(seen), 32'd33);
        valid_in = 1'b0;

        // Reset after the flit-1 handshake discards the rest of the packet.
        do_reset(1);
        valid_in = 1'b1; packet_in = 32'hAABBCCDD; node_dest_in = 3'd7; flit_ready = 1'b1;
        #1 chk("midrst_accept", 32'(ready_in), 32'd1);
        @(negedge clk);
        valid_in = 1'b0;
        #1 chk("midrst_f0", 32'(flit_out), 32'(mk(3'd5, 3'd7, 8'hAA, 5'd0, 2'd0)));
        @(negedge clk);
        #1 chk("midrst_f1", 32'(flit_out), 32'(mk(3'd5, 3'd7, 8'hBB, 5'd0, 2'd1)));
        @(negedge clk);
        rst = 1'b1; flit_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; flit_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("midrst_quiet%0d_fvalid", k), 32'(flit_valid), 32'd0);
            chk($sformatf("midrst_quiet%0d_busy", k), 32'(busy), 32'd0);
            @(negedge clk);
        end
        valid_in = 1'b1; packet_in = 32'h11223344; node_dest_in = 3'd1;
        #1 chk("midrst_next_ready", 32'(ready_in), 32'd1);
        @(negedge clk);
        valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("midrst_next_f%0d", k), 32'(flit_out),
                   32'(mk(3'd5, 3'd1, b4[k], 5'd0, 2'(k))));
            @(negedge clk);
        end

        // Ragged payload: 20 bits into three 8-bit flits, last one zero padded.
        r_valid = 1'b1; r_packet = 20'hABCDE; r_dest = 3'd4; r_fready = 1'b1;
        #1;
        chk("rag_ready", 32'(r_ready), 32'd1);
        chk("rag_fvalid0", 32'(r_fvalid), 32'd0);
        @(negedge clk);
        r_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rag_f%0d_valid", k), 32'(r_fvalid), 32'd1);
            chk($sformatf("rag_f%0d", k), 32'(r_flit), 32'(mk(3'd2, 3'd4, rb[k], 5'd0, 2'(k))));
            @(negedge clk);
        end
        #1 chk("rag_end_fvalid", 32'(r_fvalid), 32'd0);
        @(negedge clk);

        // Randomized traffic against a packet-queue reference model.
        do_reset(1);
        mq.delete(); midx = 0; mid = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ce = ($urandom_range(0, 9) != 0);
            valid_in = $urandom_range(0, 1) == 1;
            packet_in = $urandom;
            node_dest_in = 3'($urandom_range(0, 7));
            flit_ready = ($urandom_range(0, 9) < 6);
            #1;
            e_rdy = ce && (mq.size() < 2);
            e_fv  = ce && (mq.size() > 0);
            chk("rnd_ready", 32'(ready_in), 32'(e_rdy));
            chk("rnd_fvalid", 32'(flit_valid), 32'(e_fv));
            chk("rnd_busy", 32'(busy), (mq.size() != 0) ? 32'd1 : 32'd0);
            if (mq.size() > 0) begin
                sh = mq[0].pkt >> (8 * (3 - midx));
                chk("rnd_flit", 32'(flit_out),
                    32'(mk(3'd5, mq[0].dest, sh[7:0], mq[0].id, 2'(midx))));
                chk("rnd_pid", 32'(packet_id_out), 32'(mq[0].id));
            end
            acc = valid_in && e_rdy;
            if (e_fv && flit_ready) begin
                midx++;
                if (midx == 4) begin
                    void'(mq.pop_front());
                    midx = 0;
                end
            end
            if (acc) begin
                mq.push_back('{packet_in, node_dest_in, 5'(mid)});
                mid = (mid + 1) % 32;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
